// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Shares one external combinational single-adder ALU between NUM_REQ
// requesters. Each operation takes three phases:
//   IDLE : round-robin arbitration, operands of the winner are latched
//   EXEC : latched operands drive the ALU for one cycle, result captured
//   RESP : result offered to the granted requester until it is taken
//
// Ports
//   clk, rst      : clock, synchronous active-high reset
//   req_valid     : per-requester operation request
//   req_ready     : per-requester accept (one-hot or zero, IDLE only)
//   req_a, req_b  : packed operands, requester i at [i*DW +: DW]
//   req_op        : packed alu_control codes, requester i at [i*2 +: 2]
//   rsp_valid     : per-requester result valid (one-hot or zero)
//   rsp_ready     : per-requester result accept
//   rsp_y         : shared result bus, qualified by rsp_valid
//   alu_a, alu_b  : registered operands to the ALU
//   alu_control   : registered op code to the ALU
//   alu_y         : combinational result from the ALU
//   busy          : high while an operation is in EXEC or RESP
//   op_count      : completed operations, wraps modulo 2^CNT_W

module alu_share_arbiter #(
  parameter int DW      = 32,
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*DW-1:0] req_a,
  input  logic [NUM_REQ*DW-1:0] req_b,
  input  logic [NUM_REQ*2-1:0]  req_op,
  output logic [NUM_REQ-1:0]    rsp_valid,
  input  logic [NUM_REQ-1:0]    rsp_ready,
  output logic [DW-1:0]         rsp_y,
  output logic [DW-1:0]         alu_a,
  output logic [DW-1:0]         alu_b,
  output logic [1:0]            alu_control,
  input  logic [DW-1:0]         alu_y,
  output logic                  busy,
  output logic [CNT_W-1:0]      op_count
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state;
  logic [GW-1:0] last_q;
  logic [GW-1:0] g_q;
  logic [GW-1:0] win;
  logic          win_found;

  // Round-robin search: start one past the last completed grant and wrap,
  // so the requester served most recently gets the lowest priority.
  always_comb begin
    win       = '0;
    win_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!win_found && req_valid[(int'(last_q) + k) % NUM_REQ]) begin
        win_found = 1'b1;
        win       = GW'((int'(last_q) + k) % NUM_REQ);
      end
    end
  end

  // Accept is combinational so the handshake completes in the same IDLE
  // cycle the request is seen; it is never raised outside IDLE.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && win_found) begin
      req_ready[win] = 1'b1;
    end
  end

  assign busy = (state != IDLE);

  // Main sequencer. The ALU operand registers double as the latched
  // request, so they stay stable from EXEC until the next acceptance.
  // The pointer only moves when a response is taken, which means an
  // operation abandoned by reset leaves no trace in priority or count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      g_q         <= '0;
      last_q      <= GW'(NUM_REQ - 1);
      alu_a       <= '0;
      alu_b       <= '0;
      alu_control <= '0;
      rsp_y       <= '0;
      rsp_valid   <= '0;
      op_count    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            alu_a       <= req_a[int'(win)*DW +: DW];
            alu_b       <= req_b[int'(win)*DW +: DW];
            alu_control <= req_op[int'(win)*2 +: 2];
            g_q         <= win;
            state       <= EXEC;
          end
        end
        EXEC: begin
          rsp_y     <= alu_y;
          rsp_valid <= NUM_REQ'(1) << g_q;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready[g_q]) begin
            rsp_valid <= '0;
            last_q    <= g_q;
            op_count  <= op_count + 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= '0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter
// Randomised and directed stimulus against a transaction-level model of
// the arbiter. Accepted requests push their expected result into a
// scoreboard queue; a separate monitor pops and compares on each response.

module tb_alu_share_arbiter;

  localparam int DW = 32;
  localparam int N  = 4;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_a;
  logic [N*DW-1:0] req_b;
  logic [N*2-1:0]  req_op;
  logic [N-1:0]    rsp_valid;
  logic [N-1:0]    rsp_ready;
  logic [DW-1:0]   rsp_y;
  logic [DW-1:0]   alu_a;
  logic [DW-1:0]   alu_b;
  logic [1:0]      alu_control;
  logic [DW-1:0]   alu_y;
  logic            busy;
  logic [CW-1:0]   op_count;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int            id;
    logic [DW-1:0] y;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  alu_share_arbiter #(.DW(DW), .NUM_REQ(N), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .alu_y(alu_y),
    .busy(busy), .op_count(op_count)
  );

  // Reference ALU: 00 add, 01 sub, 10 and, 11 or.
  function automatic logic [DW-1:0] alu_fn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [1:0] op);
    case (op)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a & b;
      default: return a | b;
    endcase
  endfunction

  // External ALU instance stand-in.
  always_comb alu_y = alu_fn(alu_a, alu_b, alu_control);

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Transaction model: phase counts where the current operation is
  // (0 waiting for a grant, 1 executing, 2 offering the result).
  bit            m_init  = 0;
  int            m_phase = 0;
  int            m_last  = N - 1;
  int            m_g     = 0;
  int            m_count = 0;
  logic [DW-1:0] m_a = '0, m_b = '0, m_y = '0;
  logic [1:0]    m_op = '0;

  // Model process: checks every observable output against the model in
  // the middle of the cycle, then advances the model across the coming edge.
  always @(negedge clk) begin
    int           w;
    logic [N-1:0] exp_rr;
    logic [N-1:0] exp_rv;
    w = -1;
    if (m_phase == 0) begin
      for (int k = 1; k <= N; k++) begin
        if (w < 0 && req_valid[(m_last + k) % N]) w = (m_last + k) % N;
      end
    end
    if (m_init) begin
      exp_rr = (w >= 0) ? N'(1 << w) : '0;
      exp_rv = (m_phase == 2) ? N'(1 << m_g) : '0;
      checkOutput("req_ready", 64'(req_ready), 64'(exp_rr));
      checkOutput("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
      checkOutput("busy", 64'(busy), 64'(m_phase != 0));
      checkOutput("op_count", 64'(op_count), 64'(m_count));
      checkOutput("alu_a", 64'(alu_a), 64'(m_a));
      checkOutput("alu_b", 64'(alu_b), 64'(m_b));
      checkOutput("alu_control", 64'(alu_control), 64'(m_op));
      checkOutput("rsp_y_hold", 64'(rsp_y), 64'(m_y));
    end
    if (rst) begin
      m_init  = 1;
      m_phase = 0;
      m_last  = N - 1;
      m_g     = 0;
      m_count = 0;
      m_a     = '0;
      m_b     = '0;
      m_op    = '0;
      m_y     = '0;
      sb_q.delete();
    end else if (m_init) begin
      case (m_phase)
        0: if (w >= 0) begin
          exp_t e;
          m_a  = req_a[w*DW +: DW];
          m_b  = req_b[w*DW +: DW];
          m_op = req_op[w*2 +: 2];
          m_g  = w;
          e.id = w;
          e.y  = alu_fn(m_a, m_b, m_op);
          sb_q.push_back(e);
          m_phase = 1;
        end
        1: begin
          m_y     = alu_fn(m_a, m_b, m_op);
          m_phase = 2;
        end
        default: if (rsp_ready[m_g]) begin
          m_last  = m_g;
          m_count = (m_count + 1) % (1 << CW);
          m_phase = 0;
        end
      endcase
    end
  end

  // Monitor process: whenever a response is presented, compare it with
  // the oldest outstanding expectation; pop on handshake.
  bit mon_on   = 0;
  int wait_cnt = 0;
  always @(negedge clk) begin
    int id;
    if (rst) begin
      mon_on   = 1;
      wait_cnt = 0;
    end else if (mon_on) begin
      if (rsp_valid !== '0) begin
        id = -1;
        for (int i = 0; i < N; i++) if (rsp_valid[i] === 1'b1 && id < 0) id = i;
        checkOutput("rsp_onehot", 64'($countones(rsp_valid)), 64'd1);
        if (sb_q.size() == 0) begin
          n_checks++;
          $display("[TB] FAIL rsp_unexpected: rsp_valid=%b with no outstanding request", rsp_valid);
        end else begin
          checkOutput("rsp_id", 64'(id), 64'(sb_q[0].id));
          checkOutput("rsp_y", 64'(rsp_y), 64'(sb_q[0].y));
          if ((rsp_valid & rsp_ready) != '0) begin
            void'(sb_q.pop_front());
            wait_cnt = 0;
          end
        end
      end
      if (sb_q.size() != 0) begin
        wait_cnt++;
        if (wait_cnt > 60) begin
          n_checks++;
          $display("[TB] FAIL rsp_timeout: no response for requester %0d after %0d cycles",
                   sb_q[0].id, wait_cnt);
          void'(sb_q.pop_front());
          wait_cnt = 0;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic setOperands(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                             input logic [1:0] op);
    req_a[i*DW +: DW] = a;
    req_b[i*DW +: DW] = b;
    req_op[i*2 +: 2]  = op;
  endtask

  // Drive the request/response inputs and hold them for a number of cycles.
  task automatic applyStimulus(input logic [N-1:0] valid, input logic [N-1:0] rready,
                               input int cycles);
    req_valid = valid;
    rsp_ready = rready;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Round robin: all four held, distinct ops.
    setOperands(0, 32'd100, 32'd3, 2'b00);
    setOperands(1, 32'd100, 32'd3, 2'b01);
    setOperands(2, 32'd12, 32'd10, 2'b10);
    setOperands(3, 32'd12, 32'd10, 2'b11);
    applyStimulus(4'b1111, 4'b1111, 15);
    applyStimulus(4'b0000, 4'b1111, 4);

    // Single add request.
    setOperands(0, 32'd10, 32'd20, 2'b00);
    applyStimulus(4'b0001, 4'b1111, 1);
    applyStimulus(4'b0000, 4'b1111, 5);

    // Subtract wrapping below zero.
    setOperands(1, 32'd0, 32'd5, 2'b01);
    applyStimulus(4'b0010, 4'b1111, 1);
    applyStimulus(4'b0000, 4'b1111, 5);

    // Backpressure on requester 2, others still ready.
    setOperands(2, 32'd12, 32'd10, 2'b10);
    applyStimulus(4'b0100, 4'b1011, 1);
    applyStimulus(4'b0000, 4'b1011, 7);
    applyStimulus(4'b0000, 4'b1111, 4);

    // Reset during EXEC of requester 3, then a 0/3 contest.
    setOperands(3, 32'd7, 32'd1, 2'b11);
    applyStimulus(4'b1000, 4'b1111, 1);
    rst = 1'b1;
    applyStimulus(4'b0000, 4'b1111, 1);
    rst = 1'b0;
    setOperands(0, 32'd1, 32'd2, 2'b00);
    applyStimulus(4'b1001, 4'b1111, 1);
    applyStimulus(4'b0000, 4'b1111, 5);

    // Random traffic, including dropped requests and random backpressure.
    repeat (200) begin
      for (int i = 0; i < N; i++) begin
        setOperands(i, DW'($urandom), DW'($urandom), 2'($urandom_range(0, 3)));
      end
      applyStimulus(N'($urandom_range(0, 15)), N'($urandom_range(0, 15) | $urandom_range(0, 15)), 1);
    end

    // Drain.
    applyStimulus(4'b0000, 4'b1111, 10);
    checkOutput("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
